// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm edit/commit, arm/disarm and ring/snooze/timeout controller.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and btn_snooze handling.
module alarm_sequencer #(
    parameter int HW          = 5,
    parameter int MW          = 6,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int CW          = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_1hz,
    input  logic          btn_mode,
    input  logic          btn_inc,
    input  logic          btn_cancel,
    input  logic          btn_arm,
    input  logic          btn_snooze,
    input  logic          match_hh,
    input  logic          match_mm,
    input  logic          armed_in,
    output logic [HW-1:0] alarm_hh,
    output logic [MW-1:0] alarm_mm,
    output logic          set_alarm,
    output logic          arm_on,
    output logic          arm_off,
    output logic [1:0]    editing,
    output logic          ringing
);
    typedef enum logic [2:0] {
        IDLE, EDIT_HH, EDIT_MM, COMMIT, RING
`ifdef ALARM_SNOOZE_EN
        , SNOOZE
`endif
    } state_t;

    localparam logic [CW-1:0] RING_LAST = CW'(RING_SECS - 1);
`ifdef ALARM_SNOOZE_EN
    localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SECS - 1);
`else
    logic unused_snooze;
    assign unused_snooze = btn_snooze ^ SNOOZE_SECS[0];
`endif

    state_t          state_q, state_d;
    logic [HW-1:0]   com_hh_q, com_hh_d, ed_hh_q, ed_hh_d, alarm_hh_q, alarm_hh_d;
    logic [MW-1:0]   com_mm_q, com_mm_d, ed_mm_q, ed_mm_d, alarm_mm_q, alarm_mm_d;
    logic            set_alarm_q, set_alarm_d, arm_on_q, arm_on_d, arm_off_q, arm_off_d;
    logic            ringing_q, ringing_d, match_prev_q, match_prev_d;
    logic [1:0]      editing_q, editing_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            match_edge, p_mode, p_snooze, p_inc, p_arm, in_edit;

    always_comb begin
        match_prev_d = match_hh & match_mm & armed_in;
        match_edge   = match_prev_d & ~match_prev_q;
        p_mode       = btn_mode & ~btn_cancel;
`ifdef ALARM_SNOOZE_EN
        p_snooze     = btn_snooze & ~btn_cancel & ~btn_mode;
`else
        p_snooze     = 1'b0;
`endif
        p_inc        = btn_inc & ~(btn_cancel | btn_mode | p_snooze);
        p_arm        = btn_arm & ~(btn_cancel | btn_mode | p_snooze | btn_inc);
        state_d      = state_q;
        com_hh_d     = com_hh_q;
        com_mm_d     = com_mm_q;
        ed_hh_d      = ed_hh_q;
        ed_mm_d      = ed_mm_q;
        arm_on_d     = 1'b0;
        arm_off_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (match_edge) begin
                    state_d = RING;
                end else if (p_mode) begin
                    state_d = EDIT_HH;
                    ed_hh_d = com_hh_q;
                    ed_mm_d = com_mm_q;
                end else if (p_arm) begin
                    arm_on_d  = ~armed_in;
                    arm_off_d = armed_in;
                end
            end
            EDIT_HH: begin
                if (btn_cancel) state_d = IDLE;
                else if (p_mode) state_d = EDIT_MM;
                else if (p_inc) ed_hh_d = ed_hh_q == HW'(23) ? '0 : ed_hh_q + 1'b1;
            end
            EDIT_MM: begin
                if (btn_cancel) begin
                    state_d = IDLE;
                end else if (p_mode) begin
                    // committed regs take the new value on COMMIT entry so the matcher sees it with set_alarm
                    state_d  = COMMIT;
                    com_hh_d = ed_hh_q;
                    com_mm_d = ed_mm_q;
                end else if (p_inc) begin
                    ed_mm_d = ed_mm_q == MW'(59) ? '0 : ed_mm_q + 1'b1;
                end
            end
            COMMIT: state_d = IDLE;
            RING: begin
                if (btn_cancel) state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
                else if (p_snooze) state_d = SNOOZE;
`endif
                else if (tick_1hz && cnt_q == RING_LAST) state_d = IDLE;
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (btn_cancel) begin
                    state_d = IDLE;
                end else if (p_arm) begin
                    state_d   = IDLE;
                    arm_off_d = 1'b1;
                end else if (tick_1hz && cnt_q == SNOOZE_LAST) begin
                    state_d = RING;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        in_edit     = state_d == EDIT_HH || state_d == EDIT_MM;
        cnt_d       = state_d != state_q ? '0 : cnt_q + CW'(tick_1hz);
        set_alarm_d = state_d == COMMIT;
        arm_on_d    = arm_on_d | set_alarm_d;
        ringing_d   = state_d == RING;
        editing_d   = state_d == EDIT_HH ? 2'd1 : state_d == EDIT_MM ? 2'd2 : 2'd0;
        alarm_hh_d  = in_edit ? ed_hh_d : com_hh_d;
        alarm_mm_d  = in_edit ? ed_mm_d : com_mm_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            com_hh_q     <= '0;
            com_mm_q     <= '0;
            ed_hh_q      <= '0;
            ed_mm_q      <= '0;
            alarm_hh_q   <= '0;
            alarm_mm_q   <= '0;
            set_alarm_q  <= 1'b0;
            arm_on_q     <= 1'b0;
            arm_off_q    <= 1'b0;
            ringing_q    <= 1'b0;
            editing_q    <= 2'd0;
            cnt_q        <= '0;
            match_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            com_hh_q     <= com_hh_d;
            com_mm_q     <= com_mm_d;
            ed_hh_q      <= ed_hh_d;
            ed_mm_q      <= ed_mm_d;
            alarm_hh_q   <= alarm_hh_d;
            alarm_mm_q   <= alarm_mm_d;
            set_alarm_q  <= set_alarm_d;
            arm_on_q     <= arm_on_d;
            arm_off_q    <= arm_off_d;
            ringing_q    <= ringing_d;
            editing_q    <= editing_d;
            cnt_q        <= cnt_d;
            match_prev_q <= match_prev_d;
        end
    end

    assign alarm_hh  = alarm_hh_q;
    assign alarm_mm  = alarm_mm_q;
    assign set_alarm = set_alarm_q;
    assign arm_on    = arm_on_q;
    assign arm_off   = arm_off_q;
    assign editing   = editing_q;
    assign ringing   = ringing_q;
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: randomized scoreboard bench for alarm_sequencer against a behavioural model.
module tb_alarm_sequencer;
    localparam int RS = 60;
    localparam int SS = 300;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif
    localparam int M_IDLE = 0, M_EH = 1, M_EM = 2, M_RING = 3, M_SNZ = 4;

    logic       clk = 1'b0, rst = 1'b1, tick_1hz = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_cancel = 1'b0, btn_arm = 1'b0, btn_snooze = 1'b0;
    logic       match_hh = 1'b0, match_mm = 1'b0, armed_in = 1'b0;
    logic [4:0] alarm_hh;
    logic [5:0] alarm_mm;
    logic       set_alarm, arm_on, arm_off, ringing;
    logic [1:0] editing;

    alarm_sequencer dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_cancel(btn_cancel), .btn_arm(btn_arm), .btn_snooze(btn_snooze),
        .match_hh(match_hh), .match_mm(match_mm), .armed_in(armed_in),
        .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .set_alarm(set_alarm), .arm_on(arm_on),
        .arm_off(arm_off), .editing(editing), .ringing(ringing)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       sa, ao, af, ring;
        logic [1:0] ed;
        logic [4:0] hh;
        logic [5:0] mm;
    } snap_t;

    snap_t       exp_q[$];
    int          cyc_q[$];
    int          n_cmp = 0, n_bad = 0;
    bit          mon_en = 1'b0;
    logic [13:0] mon_key = '0, mdl_key = '0;

    int ms = M_IDLE, c_hh = 0, c_mm = 0, e_hh = 0, e_mm = 0, rcnt = 0;
    bit mprev = 1'b0, arm_lvl = 1'b0;

    always @(negedge clk) begin
        snap_t cur, e;
        int ec;
        if (mon_en) begin
            cur = {set_alarm, arm_on, arm_off, ringing, editing, alarm_hh, alarm_mm};
            if (set_alarm || arm_on || arm_off || cur[13:0] != mon_key) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output got=%h at cycle %0d, none expected", cur, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    if (cur !== e || ec != cyc) begin
                        n_bad++;
                        $display("FAIL output_event got=%h@%0d want=%h@%0d", cur, cyc, e, ec);
                    end
                end
            end
            mon_key = cur[13:0];
        end
    end

    function automatic snap_t mk(bit sa, bit ao, bit af);
        snap_t s;
        bit ed = ms == M_EH || ms == M_EM;
        s.sa   = sa;
        s.ao   = ao;
        s.af   = af;
        s.ring = ms == M_RING;
        s.ed   = ms == M_EH ? 2'd1 : ms == M_EM ? 2'd2 : 2'd0;
        s.hh   = 5'(ed ? e_hh : c_hh);
        s.mm   = 6'(ed ? e_mm : c_mm);
        return s;
    endfunction

    task automatic expect_out(bit sa, bit ao, bit af);
        snap_t s = mk(sa, ao, af);
        if (sa || ao || af || s[13:0] != mdl_key) begin
            exp_q.push_back(s);
            cyc_q.push_back(cyc + 1);
        end
        mdl_key = s[13:0];
    endtask

    task automatic adv();
        @(posedge clk);
        @(negedge clk);
        {rst, tick_1hz, btn_mode, btn_inc, btn_cancel, btn_arm, btn_snooze} = '0;
    endtask

    task automatic press(bit c, bit m, bit s, bit i, bit a);
        bit sa = 0, ao = 0, af = 0, commit = 0;
        {btn_cancel, btn_mode, btn_snooze, btn_inc, btn_arm} = {c, m, s, i, a};
        if (c) begin
            ms = M_IDLE;
        end else if (m) begin
            if (ms == M_IDLE) begin
                ms = M_EH; e_hh = c_hh; e_mm = c_mm;
            end else if (ms == M_EH) begin
                ms = M_EM;
            end else if (ms == M_EM) begin
                c_hh = e_hh; c_mm = e_mm; ms = M_IDLE; sa = 1; ao = 1; commit = 1;
            end
        end else if (s && SNZ) begin
            if (ms == M_RING) begin ms = M_SNZ; rcnt = 0; end
        end else if (i) begin
            if (ms == M_EH) e_hh = (e_hh + 1) % 24;
            else if (ms == M_EM) e_mm = (e_mm + 1) % 60;
        end else if (a) begin
            if (ms == M_IDLE) begin af = arm_lvl; ao = !arm_lvl; end
            else if (ms == M_SNZ) begin af = 1; ms = M_IDLE; end
        end
        expect_out(sa, ao, af);
        adv();
        if (commit) adv();
    endtask

    task automatic tick1();
        tick_1hz = 1'b1;
        if (ms == M_RING) begin
            rcnt++;
            if (rcnt == RS) ms = M_IDLE;
        end else if (ms == M_SNZ) begin
            rcnt++;
            if (rcnt == SS) begin ms = M_RING; rcnt = 0; end
        end
        expect_out(0, 0, 0);
        adv();
        repeat ($urandom_range(0, 2)) adv();
    endtask

    task automatic ticks(int n);
        repeat (n) tick1();
    endtask

    task automatic set_match(bit h, bit m, bit a);
        bit now = h & m & a;
        {match_hh, match_mm, armed_in} = {h, m, a};
        if (now && !mprev && ms == M_IDLE) begin ms = M_RING; rcnt = 0; end
        mprev   = now;
        arm_lvl = a;
        expect_out(0, 0, 0);
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {match_hh, match_mm} = 2'b00;
        ms = M_IDLE; c_hh = 0; c_mm = 0; e_hh = 0; e_mm = 0; mprev = 0;
        expect_out(0, 0, 0);
        adv();
    endtask

    task automatic edit_seq(int kh, int km, bit commit);
        press(0, 1, 0, 0, 0);
        repeat (kh) press(0, 0, 0, 1, 0);
        press(0, 1, 0, 0, 0);
        repeat (km) press(0, 0, 0, 1, 0);
        if (commit) press(0, 1, 0, 0, 0);
        else press(1, 0, 0, 0, 0);
    endtask

    task automatic chk(string nm, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_alarm_hh", int'(alarm_hh), 0);
        chk("rst_alarm_mm", int'(alarm_mm), 0);
        chk("rst_set_alarm", int'(set_alarm), 0);
        chk("rst_arm_on", int'(arm_on), 0);
        chk("rst_arm_off", int'(arm_off), 0);
        chk("rst_editing", int'(editing), 0);
        chk("rst_ringing", int'(ringing), 0);
        mon_en = 1'b1;
        edit_seq(7, 30, 1);
        edit_seq(17, 30, 0);
        set_match(0, 0, 0);
        press(0, 0, 0, 0, 1);
        set_match(0, 0, 1);
        press(0, 0, 0, 0, 1);
        set_match(1, 0, 1);
        set_match(1, 1, 1);
        ticks(RS + 5);
        set_match(0, 0, 1);
        set_match(1, 1, 1);
        ticks(10);
        press(0, 0, 1, 0, 0);
        ticks(SS);
        press(0, 0, 1, 0, 0);
        ticks(5);
        press(0, 0, 0, 0, 1);
        set_match(0, 0, 1);
        set_match(1, 1, 1);
        ticks(3);
        press(1, 0, 0, 0, 0);
        set_match(0, 0, 1);
        press(0, 1, 0, 0, 0);
        press(1, 1, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        press(0, 0, 0, 1, 1);
        press(1, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++)
            edit_seq($urandom_range(0, 30), $urandom_range(0, 70), 1'($urandom_range(0, 1)));
        for (int r = 0; r < 4; r++) begin
            set_match(0, 0, 1'($urandom_range(0, 1)));
            press(0, 0, 0, 0, 1);
        end
        set_match(1, 1, 1);
        ticks(4);
        do_reset();
        repeat (2) adv();
        press(0, 1, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        repeat (3) adv();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_outputs got=0 want=%0d pending events", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
